// File: rtl/set_bit_scanner_if.sv
// rtl/set_bit_scanner_if.sv - word-in / index-out handshake bundle for set_bit_scanner
interface set_bit_scanner_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             out_empty;
  logic             any_set;

  // Producer of words and consumer of index beats
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_index,
    input  out_last,
    input  out_empty,
    input  any_set
  );

  // The scanner itself
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_index,
    output out_last,
    output out_empty,
    output any_set
  );
endinterface

// File: rtl/set_bit_scanner.sv
// rtl/set_bit_scanner.sv - emits the index of every set bit of a word, lowest first
module set_bit_scanner #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  set_bit_scanner_if.slave     bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             empty_q, empty_d;
  logic             any_set_q, any_set_d;

  logic [IDX_W-1:0] low_idx;
  logic             single_bit;
  logic             scanning;
  logic             last_beat;

  assign scanning = (state_q == ST_SCAN);

  // Priority encoder on the work register: lowest set bit wins
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (work_q[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  // Exactly one bit remains when clearing the lowest set bit leaves nothing
  assign single_bit = (work_q != '0) && ((work_q & (work_q - WIDTH'(1))) == '0);
  assign last_beat  = scanning && (empty_q || single_bit);

  // Next-state: load on input handshake, retire lowest bit on output handshake
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    empty_d   = empty_q;
    any_set_d = any_set_q;
    if (state_q == ST_IDLE) begin
      if (bus.in_valid) begin
        work_d    = bus.in_data;
        any_set_d = |bus.in_data;
        empty_d   = (bus.in_data == '0);
        state_d   = ST_SCAN;
      end
    end else begin
      if (bus.out_ready) begin
        // x & (x-1) clears exactly the bit the encoder is reporting
        work_d = work_q & (work_q - WIDTH'(1));
        if (last_beat) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset; abandons any scan
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      work_q    <= '0;
      empty_q   <= 1'b0;
      any_set_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      empty_q   <= empty_d;
      any_set_q <= any_set_d;
    end
  end

  // Outputs come from registered state only
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = scanning;
  assign bus.out_index = (scanning && !empty_q) ? low_idx : '0;
  assign bus.out_last  = last_beat;
  assign bus.out_empty = scanning && empty_q;
  assign bus.any_set   = any_set_q;

endmodule

// File: tb/tb_set_bit_scanner.sv
// tb/tb_set_bit_scanner.sv - directed and random checks of set_bit_scanner against a bit-list model
module tb_set_bit_scanner;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  set_bit_scanner_if #(.WIDTH(32), .IDX_W(5)) bus ();

  set_bit_scanner #(.WIDTH(32), .IDX_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list of set bit positions in ascending order; a zero word yields one marker beat
  task automatic model_beats(input logic [31:0] w, output int idx_q[$]);
    idx_q = {};
    for (int i = 0; i < 32; i++) begin
      if (((w >> i) & 32'd1) != 0) idx_q.push_back(i);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Loads one word, optionally stalls the first beat, and checks every beat against the model
  task automatic run_word(input logic [31:0] w, input int stall, input bit poke_in);
    int exp_q[$];
    int n;
    @(negedge clock);
    check("pre_ready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    model_beats(w, exp_q);
    n = (exp_q.size() == 0) ? 1 : exp_q.size();
    check("any_set", {31'd0, bus.any_set}, {31'd0, w != 32'd0});
    for (int k = 0; k < n; k++) begin
      int exp_idx;
      exp_idx = (exp_q.size() == 0) ? 0 : exp_q[k];
      if (k == 0 && stall > 0) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          if (poke_in) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h0000_0001;
          end
          check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
          check("stall_index", {27'd0, bus.out_index}, exp_idx);
          check("stall_inrdy", {31'd0, bus.in_ready}, 32'd0);
          @(negedge clock);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
      end
      check("beat_valid", {31'd0, bus.out_valid}, 32'd1);
      check("beat_index", {27'd0, bus.out_index}, exp_idx);
      check("beat_last", {31'd0, bus.out_last}, {31'd0, k == n - 1});
      check("beat_empty", {31'd0, bus.out_empty}, {31'd0, w == 32'd0});
      check("beat_inrdy", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clock);
    end
    check_idle("post");
    check("post_any_set", {31'd0, bus.any_set}, {31'd0, w != 32'd0});
  endtask

  initial begin
    int exp_q[$];
    logic [31:0] w;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #2;
    check_idle("rst");
    check("rst_index", {27'd0, bus.out_index}, 32'd0);
    check("rst_last", {31'd0, bus.out_last}, 32'd0);
    check("rst_empty", {31'd0, bus.out_empty}, 32'd0);
    check("rst_any", {31'd0, bus.any_set}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed words: zero, sparse, dense, backpressure with ignored in_valid
    run_word(32'h0000_0000, 0, 1'b0);
    run_word(32'h8000_0001, 0, 1'b0);
    run_word(32'hFFFF_FFFF, 0, 1'b0);
    run_word(32'h0000_0104, 3, 1'b1);

    // Reset mid-scan after the beat at index 4
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_00F0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("mid_idx4", {27'd0, bus.out_index}, 32'd4);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("mid_rst");
    check("mid_rst_any", {31'd0, bus.any_set}, 32'd0);
    check("mid_rst_index", {27'd0, bus.out_index}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("mid_hold_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    reset_n = 1'b1;
    run_word(32'h0000_0002, 0, 1'b0);

    // Back-to-back with in_valid held
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0003;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.in_data = 32'h0000_0004;
    check("b2b_i0", {27'd0, bus.out_index}, 32'd0);
    check("b2b_l0", {31'd0, bus.out_last}, 32'd0);
    check("b2b_any0", {31'd0, bus.any_set}, 32'd1);
    @(negedge clock);
    check("b2b_i1", {27'd0, bus.out_index}, 32'd1);
    check("b2b_l1", {31'd0, bus.out_last}, 32'd1);
    @(negedge clock);
    check_idle("b2b_gap");
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("b2b_v2", {31'd0, bus.out_valid}, 32'd1);
    check("b2b_i2", {27'd0, bus.out_index}, 32'd2);
    check("b2b_l2", {31'd0, bus.out_last}, 32'd1);
    check("b2b_any2", {31'd0, bus.any_set}, 32'd1);
    @(negedge clock);
    check_idle("b2b_end");

    // Randomized words of varying density and stalls
    for (int r = 0; r < 24; r++) begin
      case (r % 3)
        0: w = $urandom;
        1: w = $urandom & $urandom & $urandom;
        default: w = 32'd1 << $urandom_range(31, 0);
      endcase
      run_word(w, $urandom_range(2, 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
